axi_req_master: RTL and testbench

//  Single-outstanding AXI4 initiator: turns a simple valid/ready word request port (debug

---
 rtl/utils_pkg.sv | 62 ++++++
 rtl/axi_req_master.sv | 185 ++++++++++++++++++
 tb/tb_axi_req_master.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/utils_pkg.sv
// Shared AXI4 constants, bus structs and the request-master state type.
// Used by axi_req_master (optional macro there: AXI_REQ_MASTER_ALIGN_CHK_EN).
package utils_pkg;

  localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_D = 3'd4,
    RSP  = 3'd5
  } axi_req_mst_st_t;

  // Manager -> subordinate signals (32-bit address/data, 1-bit ID)
  typedef struct packed {
    logic        awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic        arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
  } s_axi_mosi_t;

  // Subordinate -> manager signals
  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic        rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/axi_req_master.sv
// Single-outstanding AXI4 initiator: one word request in, one single-beat
// AXI read or write out, one response back. All AXI outputs come from flops.
// Optional macro AXI_REQ_MASTER_ALIGN_CHK_EN: misaligned requests are answered
// locally with SLVERR and never reach the bus.
module axi_req_master
  import utils_pkg::*;
#(
  parameter logic       AXI_ID   = 1'b0,
  parameter logic [2:0] AXI_PROT = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_err,
  output s_axi_mosi_t axi_mosi,
  input  s_axi_miso_t axi_miso
);

  axi_req_mst_st_t state_q, state_d;
  s_axi_mosi_t     mosi_q, mosi_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic misaligned;
  logic unused_miso;

  assign aw_hs = mosi_q.awvalid & axi_miso.awready;
  assign w_hs  = mosi_q.wvalid  & axi_miso.wready;
  assign b_hs  = mosi_q.bready  & axi_miso.bvalid;
  assign ar_hs = mosi_q.arvalid & axi_miso.arready;
  assign r_hs  = mosi_q.rready  & axi_miso.rvalid;

  // Responses are not ID-checked and every read is a single beat
  assign unused_miso = ^{axi_miso.bid, axi_miso.rid, axi_miso.rlast};

`ifdef AXI_REQ_MASTER_ALIGN_CHK_EN
  assign misaligned = |req_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // Next-state, AXI output and response-capture logic
  always_comb begin
    state_d     = state_q;
    mosi_d      = mosi_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            // Answered locally, no bus traffic
            rsp_rdata_d = '0;
            rsp_resp_d  = AXI_RESP_SLVERR;
            state_d     = RSP;
          end else if (req_we) begin
            mosi_d.awaddr  = req_addr;
            mosi_d.wdata   = req_wdata;
            mosi_d.wstrb   = req_wstrb;
            mosi_d.awvalid = 1'b1;
            mosi_d.wvalid  = 1'b1;
            aw_done_d      = 1'b0;
            w_done_d       = 1'b0;
            state_d        = WR;
          end else begin
            mosi_d.araddr  = req_addr;
            mosi_d.arvalid = 1'b1;
            state_d        = RD_A;
          end
        end
      end

      WR: begin
        // Address and data channels complete independently, in any order
        if (aw_hs) begin
          mosi_d.awvalid = 1'b0;
          aw_done_d      = 1'b1;
        end
        if (w_hs) begin
          mosi_d.wvalid = 1'b0;
          w_done_d      = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          mosi_d.bready = 1'b1;
          state_d       = WR_B;
        end
      end

      WR_B: begin
        if (b_hs) begin
          mosi_d.bready = 1'b0;
          rsp_rdata_d   = '0;
          rsp_resp_d    = axi_miso.bresp;
          state_d       = RSP;
        end
      end

      RD_A: begin
        if (ar_hs) begin
          mosi_d.arvalid = 1'b0;
          mosi_d.rready  = 1'b1;
          state_d        = RD_D;
        end
      end

      RD_D: begin
        if (r_hs) begin
          mosi_d.rready = 1'b0;
          rsp_rdata_d   = axi_miso.rdata;
          rsp_resp_d    = axi_miso.rresp;
          state_d       = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Constant fields: single-beat word INCR, no lock/cache attributes
    mosi_d.awid    = AXI_ID;
    mosi_d.awlen   = 8'd0;
    mosi_d.awsize  = AXI_SIZE_WORD;
    mosi_d.awburst = AXI_BURST_INCR;
    mosi_d.awlock  = 1'b0;
    mosi_d.awcache = 4'd0;
    mosi_d.awprot  = AXI_PROT;
    mosi_d.wlast   = 1'b1;
    mosi_d.arid    = AXI_ID;
    mosi_d.arlen   = 8'd0;
    mosi_d.arsize  = AXI_SIZE_WORD;
    mosi_d.arburst = AXI_BURST_INCR;
    mosi_d.arlock  = 1'b0;
    mosi_d.arcache = 4'd0;
    mosi_d.arprot  = AXI_PROT;
  end

  // State and output registers; reset clears every AXI field
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      mosi_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      mosi_q      <= mosi_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_err   = rsp_resp_q[1];
  assign axi_mosi  = mosi_q;

endmodule

// File: tb/tb_axi_req_master.sv
// Directed bench for axi_req_master driving a small 4 KB AXI RAM model with
// controllable (fixed or random) ready/valid stalls.
module tb_axi_req_master;
  import utils_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_err;
  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;

  int n_checks = 0;
  int n_fail   = 0;

  axi_req_master dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .rsp_err   (rsp_err),
    .axi_mosi  (axi_mosi),
    .axi_miso  (axi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AXI RAM model ----------------
  logic [31:0] mem [0:1023];
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_addr_s, w_data_s, rdata_s;
  logic [3:0]  w_strb_s;
  logic [1:0]  bresp_s, rresp_s;
  logic        aw_fix, w_fix, ar_fix, b_fix, rand_mode;
  logic        aw_rnd, w_rnd, ar_rnd, b_rnd;
  logic        aw_gate, w_gate, ar_gate, b_gate;
  logic        s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;

  assign aw_gate = rand_mode ? aw_rnd : aw_fix;
  assign w_gate  = rand_mode ? w_rnd  : w_fix;
  assign ar_gate = rand_mode ? ar_rnd : ar_fix;
  assign b_gate  = rand_mode ? b_rnd  : b_fix;

  always @(negedge clk) begin
    aw_rnd = ($urandom_range(0, 2) != 0);
    w_rnd  = ($urandom_range(0, 2) != 0);
    ar_rnd = ($urandom_range(0, 2) != 0);
    b_rnd  = ($urandom_range(0, 2) != 0);
  end

  always_comb begin
    axi_miso         = '0;
    axi_miso.awready = !aw_got && aw_gate;
    axi_miso.wready  = !w_got && w_gate;
    axi_miso.bvalid  = b_pend && b_gate;
    axi_miso.bresp   = bresp_s;
    axi_miso.arready = !r_pend && ar_gate;
    axi_miso.rvalid  = r_pend;
    axi_miso.rdata   = rdata_s;
    axi_miso.rresp   = rresp_s;
    axi_miso.rlast   = 1'b1;
  end

  assign s_aw_hs = axi_mosi.awvalid && axi_miso.awready;
  assign s_w_hs  = axi_mosi.wvalid  && axi_miso.wready;
  assign s_b_hs  = axi_mosi.bready  && axi_miso.bvalid;
  assign s_ar_hs = axi_mosi.arvalid && axi_miso.arready;
  assign s_r_hs  = axi_mosi.rready  && axi_miso.rvalid;

  logic [31:0] wa, wd;
  logic [3:0]  ws;
  always @(posedge clk) begin
    if (!rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
      rdata_s <= '0; bresp_s <= '0; rresp_s <= '0;
    end else begin
      if (s_aw_hs) begin aw_got <= 1'b1; aw_addr_s <= axi_mosi.awaddr; end
      if (s_w_hs) begin w_got <= 1'b1; w_data_s <= axi_mosi.wdata; w_strb_s <= axi_mosi.wstrb; end
      if (!b_pend && (aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
        wa = aw_got ? aw_addr_s : axi_mosi.awaddr;
        wd = w_got ? w_data_s : axi_mosi.wdata;
        ws = w_got ? w_strb_s : axi_mosi.wstrb;
        if (wa[31:12] == 20'd0) begin
          for (int b = 0; b < 4; b++)
            if (ws[b]) mem[wa[11:2]][8*b +: 8] <= wd[8*b +: 8];
          bresp_s <= AXI_RESP_OKAY;
        end else begin
          bresp_s <= AXI_RESP_SLVERR;
        end
        b_pend <= 1'b1;
      end
      if (s_b_hs) begin b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; end
      if (s_ar_hs) begin
        r_pend  <= 1'b1;
        rdata_s <= (axi_mosi.araddr[31:12] == 20'd0) ? mem[axi_mosi.araddr[11:2]] : 32'd0;
        rresp_s <= (axi_mosi.araddr[31:12] == 20'd0) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
      if (s_r_hs) r_pend <= 1'b0;
    end
  end

  // ---------------- bus monitors ----------------
  int aw_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, viol = 0;
  logic p_rst = 1'b0, p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  always @(posedge clk) begin
    if (s_aw_hs) aw_hs_cnt <= aw_hs_cnt + 1;
    if (s_b_hs)  b_hs_cnt  <= b_hs_cnt + 1;
    if (s_ar_hs) ar_hs_cnt <= ar_hs_cnt + 1;
    if (rst && p_rst) begin
      if (p_aw && (!axi_mosi.awvalid || axi_mosi.awaddr != p_awaddr)) viol <= viol + 1;
      if (p_w  && (!axi_mosi.wvalid  || axi_mosi.wdata  != p_wdata))  viol <= viol + 1;
      if (p_ar && (!axi_mosi.arvalid || axi_mosi.araddr != p_araddr)) viol <= viol + 1;
    end
    p_rst    <= rst;
    p_aw     <= axi_mosi.awvalid && !axi_miso.awready;
    p_w      <= axi_mosi.wvalid  && !axi_miso.wready;
    p_ar     <= axi_mosi.arvalid && !axi_miso.arready;
    p_awaddr <= axi_mosi.awaddr;
    p_wdata  <= axi_mosi.wdata;
    p_araddr <= axi_mosi.araddr;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full request/response transaction; hold>0 keeps rsp_ready low that many cycles
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int hold,
                        output logic [31:0] rdata, output logic [1:0] resp,
                        output logic err, output int lat);
    int n;
    int bad;
    logic [31:0] r0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check_eq("accept_wait_expired", 32'(n >= 100), 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check_eq("rsp_wait_expired", 32'(lat >= 200), 0);
    rdata = rsp_rdata; resp = rsp_resp; err = rsp_err;
    if (hold > 0) begin
      bad = 0; r0 = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!rsp_valid || rsp_rdata != r0 || req_ready ||
            axi_mosi.awvalid || axi_mosi.wvalid || axi_mosi.arvalid ||
            axi_mosi.bready || axi_mosi.rready) bad++;
      end
      check_eq("rsp_hold_bad_cycles", bad, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("req_ready_after_rsp", 32'(req_ready), 1);
    $display("txn we=%0d addr=%08h wdata=%08h strb=%h -> rdata=%08h resp=%0d err=%0d lat=%0d",
             we, addr, data, strb, rdata, resp, err, lat);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [4];

  logic [31:0] rd;
  logic [1:0]  rs;
  logic        er;
  int          lt;
  int          base_b, base_ar, base_aw, n_wait, bad3;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; rsp_ready = 1'b0;
    rand_mode = 1'b0; aw_fix = 1'b1; w_fix = 1'b1; ar_fix = 1'b1; b_fix = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check_eq("rst_req_ready", 32'(req_ready), 1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_rsp_resp", 32'(rsp_resp), 0);
    check_eq("rst_mosi_zero", 32'(|axi_mosi), 0);
    @(negedge clk); rst = 1'b1;

    // 1: write then read back, zero-wait slave
    do_req(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 0, rd, rs, er, lt);
    check_eq("t1_wr_resp", 32'(rs), 0);
    check_eq("t1_wr_rdata", rd, 0);
    check_eq("t1_wr_lat", lt, 3);
    check_eq("t1_awsize", 32'(axi_mosi.awsize), 32'b010);
    check_eq("t1_awburst", 32'(axi_mosi.awburst), 32'b01);
    check_eq("t1_wlast", 32'(axi_mosi.wlast), 1);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, rs, er, lt);
    check_eq("t1_rd_data", rd, 32'hDEAD_BEEF);
    check_eq("t1_rd_resp", 32'(rs), 0);
    check_eq("t1_rd_lat", lt, 3);

    // 2: partial strobes merge into existing word
    do_req(1'b1, 32'h44, 32'hFFFF_FFFF, 4'hF, 0, rd, rs, er, lt);
    do_req(1'b1, 32'h44, 32'h1234_5678, 4'b0011, 0, rd, rs, er, lt);
    do_req(1'b0, 32'h44, 32'h0, 4'h0, 0, rd, rs, er, lt);
    check_eq("t2_rd_merge", rd, 32'hFFFF_5678);

    // 3: wready stalled after the address handshake
    w_fix = 1'b0; base_aw = aw_hs_cnt; base_b = b_hs_cnt; bad3 = 0;
    fork
      do_req(1'b1, 32'h48, 32'hA5A5_5A5A, 4'hF, 0, rd, rs, er, lt);
      begin
        n_wait = 0;
        while (aw_hs_cnt == base_aw && n_wait < 50) begin @(negedge clk); n_wait++; end
        check_eq("t3_aw_wait_expired", 32'(n_wait >= 50), 0);
        repeat (5) begin
          @(negedge clk);
          if (!axi_mosi.wvalid || axi_mosi.wdata != 32'hA5A5_5A5A || axi_mosi.awvalid) bad3++;
        end
        w_fix = 1'b1;
      end
    join
    check_eq("t3_wvalid_held", bad3, 0);
    check_eq("t3_one_bresp", b_hs_cnt - base_b, 1);
    check_eq("t3_wr_resp", 32'(rs), 0);
    do_req(1'b0, 32'h48, 32'h0, 4'h0, 0, rd, rs, er, lt);
    check_eq("t3_rd_data", rd, 32'hA5A5_5A5A);

    // 4: response held 10 cycles
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 10, rd, rs, er, lt);
    check_eq("t4_rd_data", rd, 32'hDEAD_BEEF);

    // 5: reset while waiting for the write response
    b_fix = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_wdata = 32'h1111_2222; req_wstrb = 4'hF;
    @(posedge clk); #1; req_valid = 1'b0;
    n_wait = 0;
    while (!axi_mosi.bready && n_wait < 20) begin @(posedge clk); #1; n_wait++; end
    check_eq("t5_reached_wr_b", 32'(axi_mosi.bready), 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_valids_cleared", 32'({axi_mosi.awvalid, axi_mosi.wvalid, axi_mosi.arvalid,
                                        axi_mosi.bready, axi_mosi.rready}), 0);
    check_eq("t5_req_ready", 32'(req_ready), 1);
    check_eq("t5_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk); rst = 1'b1; b_fix = 1'b1;
    do_req(1'b1, 32'h80, 32'h3333_4444, 4'hF, 0, rd, rs, er, lt);
    check_eq("t5_wr_resp", 32'(rs), 0);
    do_req(1'b0, 32'h80, 32'h0, 4'h0, 0, rd, rs, er, lt);
    check_eq("t5_rd_data", rd, 32'h3333_4444);

    // Out-of-range address: slave error propagates
    do_req(1'b1, 32'h0000_2000, 32'h0, 4'hF, 0, rd, rs, er, lt);
    check_eq("oor_wr_resp", 32'(rs), 32'b10);
    check_eq("oor_wr_err", 32'(er), 1);

    // Random-stall write/read pairs
    vecs[0] = '{32'h100, 32'h0102_0304, 4'hF,    32'h0102_0304};
    vecs[1] = '{32'h104, 32'hCAFE_F00D, 4'hF,    32'hCAFE_F00D};
    vecs[2] = '{32'h100, 32'hAABB_CCDD, 4'b1100, 32'hAABB_0304};
    vecs[3] = '{32'hFFC, 32'h5555_AAAA, 4'hF,    32'h5555_AAAA};
    rand_mode = 1'b1;
    foreach (vecs[i]) begin
      do_req(1'b1, vecs[i].addr, vecs[i].data, vecs[i].strb, 0, rd, rs, er, lt);
      check_eq("rnd_wr_resp", 32'(rs), 0);
      do_req(1'b0, vecs[i].addr, 32'h0, 4'h0, 0, rd, rs, er, lt);
      check_eq("rnd_rd_data", rd, vecs[i].exp);
    end
    rand_mode = 1'b0;

    // 6: misaligned request
    base_ar = ar_hs_cnt;
    do_req(1'b0, 32'h42, 32'h0, 4'h0, 0, rd, rs, er, lt);
`ifdef AXI_REQ_MASTER_ALIGN_CHK_EN
    check_eq("t6_no_ar", ar_hs_cnt - base_ar, 0);
    check_eq("t6_lat", lt, 1);
    check_eq("t6_resp", 32'(rs), 32'b10);
    check_eq("t6_err", 32'(er), 1);
    check_eq("t6_rdata", rd, 0);
`else
    check_eq("t6_one_ar", ar_hs_cnt - base_ar, 1);
    check_eq("t6_resp", 32'(rs), 0);
    check_eq("t6_rdata", rd, 32'hDEAD_BEEF);
`endif

    check_eq("bus_stability_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
